adsr_envelope: RTL and testbench

Amplitude envelope stage directly downstream of the oscillator. It takes the oscillator's raw sample `v` and a key gate, and runs an attack/decay/sustain/release state machine that produces an envelope level. It outputs the oscillator sample scaled by that level around midscale. Its output feeds the mixer/DAC path, and silence is exact midscale.

---
 rtl/adsr_envelope_pkg.sv | 23 ++
 rtl/adsr_envelope_if.sv | 18 +
 rtl/adsr_envelope_env_scaler.sv | 37 +++
 rtl/adsr_envelope.sv | 130 +++++++++++++
 tb/tb_adsr_envelope.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/adsr_envelope_pkg.sv
// Shared types and constants for the ADSR envelope stage: oscillator depth, key type,
// envelope state encodings and the default envelope width.
package adsr_envelope_pkg;

    localparam int OSC_DEPTH     = 12;
    localparam int ENV_WIDTH_DEF = 16;

    typedef logic [6:0] key_t;

    typedef enum logic [2:0] {
        ENV_IDLE    = 3'd0,
        ENV_ATTACK  = 3'd1,
        ENV_DECAY   = 3'd2,
        ENV_SUSTAIN = 3'd3,
        ENV_RELEASE = 3'd4
    } env_state_t;

    // Offset-binary zero point of an oscillator sample.
    function automatic logic [OSC_DEPTH-1:0] osc_mid();
        return {1'b1, {(OSC_DEPTH-1){1'b0}}};
    endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Signal bundle between the oscillator/key source and the envelope stage.
// No handshake: gate/k/v_in are sampled every clk; v_out/env/active/state update every clk.
interface adsr_envelope_if
    import adsr_envelope_pkg::*;
#(
    parameter int ENV_WIDTH = ENV_WIDTH_DEF
);
    logic                 gate;
    key_t                 k;
    logic [OSC_DEPTH-1:0] v_in;
    logic [OSC_DEPTH-1:0] v_out;
    logic [ENV_WIDTH-1:0] env;
    logic                 active;
    env_state_t           state;

    modport master (output gate, k, v_in, input v_out, env, active, state);
    modport slave  (input gate, k, v_in, output v_out, env, active, state);
endinterface

// File: rtl/adsr_envelope_env_scaler.sv
// Two-stage pipeline scaling an offset-binary sample by the envelope level around midscale:
// stage 1 registers (v_in - mid) * env, stage 2 registers mid + (product >>> ENV_WIDTH).
module env_scaler
    import adsr_envelope_pkg::*;
#(
    parameter int ENV_WIDTH = ENV_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OSC_DEPTH-1:0] v_in_i,
    input  logic [ENV_WIDTH-1:0] env_i,
    output logic [OSC_DEPTH-1:0] v_out_o
);
    localparam int PW = OSC_DEPTH + ENV_WIDTH + 2;

    logic signed [OSC_DEPTH:0] d;
    logic signed [PW-1:0]      p_d, p_q, sh;
    logic [OSC_DEPTH-1:0]      v_d, v_q;

    assign d   = signed'({1'b0, v_in_i} - {1'b0, osc_mid()});
    assign p_d = PW'(d) * PW'(signed'({1'b0, env_i}));
    // Truncating the shifted product to OSC_DEPTH bits keeps its two's-complement value.
    assign sh  = p_q >>> ENV_WIDTH;
    assign v_d = osc_mid() + sh[OSC_DEPTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
            v_q <= osc_mid();
        end else begin
            p_q <= p_d;
            v_q <= v_d;
        end
    end

    assign v_out_o = v_q;
endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate edge detection, free-running tick divider, envelope FSM,
// and the env_scaler output pipeline. ADSR_RETRIGGER_EN enables restart on key change.
module adsr_envelope
    import adsr_envelope_pkg::*;
#(
    parameter int ENV_WIDTH     = ENV_WIDTH_DEF,
    parameter int TICK_DIV      = 1000,
    parameter int ATTACK_STEP   = 64,
    parameter int DECAY_STEP    = 16,
    parameter int SUSTAIN_LEVEL = 32768,
    parameter int RELEASE_STEP  = 32
) (
    input  logic                clk,
    input  logic                rst,
    adsr_envelope_if.slave      bus
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ENV_WIDTH:0] FULL   = {1'b0, {ENV_WIDTH{1'b1}}};
    localparam logic [ENV_WIDTH:0] A_STEP = (ENV_WIDTH+1)'(ATTACK_STEP);
    localparam logic [ENV_WIDTH:0] D_STEP = (ENV_WIDTH+1)'(DECAY_STEP);
    localparam logic [ENV_WIDTH:0] R_STEP = (ENV_WIDTH+1)'(RELEASE_STEP);
    localparam logic [ENV_WIDTH:0] SUS    = (ENV_WIDTH+1)'(SUSTAIN_LEVEL);

    env_state_t           state_q, state_d;
    logic [ENV_WIDTH-1:0] env_q, env_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 gate_q;
    logic                 tick, rise, fall, retrig;
    logic [ENV_WIDTH:0]   sum, dec_diff, rel_diff;

    assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign rise = bus.gate & ~gate_q;
    assign fall = ~bus.gate & gate_q;

`ifdef ADSR_RETRIGGER_EN
    key_t k_q;
    always_ff @(posedge clk) begin
        if (rst) k_q <= '0;
        else     k_q <= bus.k;
    end
    assign retrig = bus.gate && (bus.k != k_q) && (state_q != ENV_RELEASE);
`else
    logic unused_k;
    assign unused_k = ^bus.k;
    assign retrig   = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        env_d    = env_q;
        cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
        sum      = {1'b0, env_q} + A_STEP;
        dec_diff = {1'b0, env_q} - D_STEP;
        rel_diff = {1'b0, env_q} - R_STEP;
        // Edges are tested before the tick so a coincident tick leaves env untouched.
        case (state_q)
            ENV_IDLE: begin
                if (rise || retrig) state_d = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (fall) state_d = ENV_RELEASE;
                else if (!retrig && tick) begin
                    if (sum >= FULL) begin
                        env_d   = FULL[ENV_WIDTH-1:0];
                        state_d = ENV_DECAY;
                    end else begin
                        env_d = sum[ENV_WIDTH-1:0];
                    end
                end
            end
            ENV_DECAY: begin
                if (fall) state_d = ENV_RELEASE;
                else if (retrig) state_d = ENV_ATTACK;
                else if (tick) begin
                    if (dec_diff[ENV_WIDTH] || (dec_diff <= SUS)) begin
                        env_d   = SUS[ENV_WIDTH-1:0];
                        state_d = ENV_SUSTAIN;
                    end else begin
                        env_d = dec_diff[ENV_WIDTH-1:0];
                    end
                end
            end
            ENV_SUSTAIN: begin
                if (fall) state_d = ENV_RELEASE;
                else if (retrig) state_d = ENV_ATTACK;
            end
            ENV_RELEASE: begin
                if (rise) state_d = ENV_ATTACK;
                else if (tick) begin
                    if (rel_diff[ENV_WIDTH] || (rel_diff == '0)) begin
                        env_d   = '0;
                        state_d = ENV_IDLE;
                    end else begin
                        env_d = rel_diff[ENV_WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = ENV_IDLE;
                env_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ENV_IDLE;
            env_q   <= '0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            gate_q  <= bus.gate;
        end
    end

    assign bus.env    = env_q;
    assign bus.active = (state_q != ENV_IDLE);
    assign bus.state  = state_q;

    env_scaler #(.ENV_WIDTH(ENV_WIDTH)) u_scaler (
        .clk     (clk),
        .rst     (rst),
        .v_in_i  (bus.v_in),
        .env_i   (env_q),
        .v_out_o (bus.v_out)
    );
endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope: instance a (TICK_DIV=1) for the note shapes,
// instance b (TICK_DIV=4) for tick/edge collision and full-scale scaling.
module tb_adsr_envelope;
    import adsr_envelope_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    adsr_envelope_if #(.ENV_WIDTH(8)) bus_a ();
    adsr_envelope_if #(.ENV_WIDTH(8)) bus_b ();

    adsr_envelope #(
        .ENV_WIDTH(8), .TICK_DIV(1), .ATTACK_STEP(64), .DECAY_STEP(16),
        .SUSTAIN_LEVEL(128), .RELEASE_STEP(32)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    adsr_envelope #(
        .ENV_WIDTH(8), .TICK_DIV(4), .ATTACK_STEP(64), .DECAY_STEP(16),
        .SUSTAIN_LEVEL(128), .RELEASE_STEP(32)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    initial begin
        int env_seq[12];
        env_seq = '{64, 128, 192, 255, 239, 223, 207, 191, 175, 159, 143, 128};

        // Clock/reset
        rst = 1'b1;
        bus_a.gate = 1'b0; bus_a.k = 7'd25; bus_a.v_in = 12'd2048;
        bus_b.gate = 1'b0; bus_b.k = 7'd25; bus_b.v_in = 12'd4095;
        repeat (3) step();
        chk("rst_env_a", int'(bus_a.env), 0);
        chk("rst_active_a", int'(bus_a.active), 0);
        chk("rst_vout_a", int'(bus_a.v_out), 2048);
        chk("rst_state_b", int'(bus_b.state), int'(ENV_IDLE));
        chk("rst_vout_b", int'(bus_b.v_out), 2048);
        rst = 1'b0;

        // Tick/edge collision on b: ticks land on the 4th, 8th, ... edge after reset
        repeat (3) step();
        chk("b_idle_pre", int'(bus_b.state), int'(ENV_IDLE));
        bus_b.gate = 1'b1;
        step();
        chk("b_collide_state", int'(bus_b.state), int'(ENV_ATTACK));
        chk("b_collide_env", int'(bus_b.env), 0);
        repeat (3) step();
        chk("b_env_before_tick", int'(bus_b.env), 0);
        step();
        chk("b_first_inc", int'(bus_b.env), 64);
        repeat (12) step();
        chk("b_full", int'(bus_b.env), 255);
        chk("b_decay", int'(bus_b.state), int'(ENV_DECAY));
        repeat (2) step();
        chk("b_scale_pos", int'(bus_b.v_out), 4087);
        bus_b.v_in = 12'd0;
        step();
        chk("b_scale_latency", int'(bus_b.v_out), 4087);
        step();
        chk("b_scale_neg", int'(bus_b.v_out), 8);
        chk("b_decay_env", int'(bus_b.env), 239);
        bus_b.gate = 1'b0;

        // Full note on a
        bus_a.gate = 1'b1;
        step();
        chk("a_rise_state", int'(bus_a.state), int'(ENV_ATTACK));
        chk("a_rise_env", int'(bus_a.env), 0);
        chk("a_rise_active", int'(bus_a.active), 1);
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("a_note_env%0d", i), int'(bus_a.env), env_seq[i]);
        end
        chk("a_sustain", int'(bus_a.state), int'(ENV_SUSTAIN));

        // Scaling at env=128, two-cycle latency
        bus_a.v_in = 12'd4095;
        step();
        chk("a_scale_lat", int'(bus_a.v_out), 2048);
        step();
        chk("a_scale_pos", int'(bus_a.v_out), 3071);
        bus_a.v_in = 12'd0;
        repeat (2) step();
        chk("a_scale_neg", int'(bus_a.v_out), 1024);
        chk("a_sustain_hold", int'(bus_a.env), 128);

        // Release to idle
        bus_a.gate = 1'b0;
        step();
        chk("a_fall_state", int'(bus_a.state), int'(ENV_RELEASE));
        chk("a_fall_env", int'(bus_a.env), 128);
        step(); chk("a_rel96", int'(bus_a.env), 96);
        step(); chk("a_rel64", int'(bus_a.env), 64);
        step(); chk("a_rel32", int'(bus_a.env), 32);
        step();
        chk("a_rel0", int'(bus_a.env), 0);
        chk("a_idle", int'(bus_a.state), int'(ENV_IDLE));
        chk("a_idle_active", int'(bus_a.active), 0);
        bus_a.v_in = 12'd4095;
        repeat (2) step();
        chk("a_env0_mid", int'(bus_a.v_out), 2048);

        // Early release and re-attack from current level
        bus_a.v_in = 12'd2048;
        bus_a.gate = 1'b1;
        step(); chk("er_attack", int'(bus_a.state), int'(ENV_ATTACK));
        step(); chk("er_64", int'(bus_a.env), 64);
        step(); chk("er_128", int'(bus_a.env), 128);
        bus_a.gate = 1'b0;
        step();
        chk("er_rel_state", int'(bus_a.state), int'(ENV_RELEASE));
        chk("er_rel_hold", int'(bus_a.env), 128);
        step(); chk("er_96", int'(bus_a.env), 96);
        step(); chk("er_64b", int'(bus_a.env), 64);
        bus_a.gate = 1'b1;
        step();
        chk("er_reattack", int'(bus_a.state), int'(ENV_ATTACK));
        chk("er_reattack_env", int'(bus_a.env), 64);
        step(); chk("er_resume128", int'(bus_a.env), 128);
        step(); chk("er_resume192", int'(bus_a.env), 192);
        step(); chk("er_255", int'(bus_a.env), 255);
        repeat (8) step();
        chk("er_sustain", int'(bus_a.state), int'(ENV_SUSTAIN));
        chk("er_sustain_env", int'(bus_a.env), 128);

        // Key change in sustain
        bus_a.k = 7'd26;
        bus_a.v_in = 12'd4095;
        step();
`ifdef ADSR_RETRIGGER_EN
        chk("rt_state", int'(bus_a.state), int'(ENV_ATTACK));
`else
        chk("rt_state", int'(bus_a.state), int'(ENV_SUSTAIN));
`endif
        chk("rt_env", int'(bus_a.env), 128);
        step();
        chk("rt_vout", int'(bus_a.v_out), 3071);

        // Reset mid-note with gate held, then re-rise after release
        rst = 1'b1;
        step();
        chk("mr_state", int'(bus_a.state), int'(ENV_IDLE));
        chk("mr_env", int'(bus_a.env), 0);
        chk("mr_active", int'(bus_a.active), 0);
        chk("mr_vout", int'(bus_a.v_out), 2048);
        step();
        rst = 1'b0;
        step();
        chk("mr_rise_state", int'(bus_a.state), int'(ENV_ATTACK));
        chk("mr_rise_env", int'(bus_a.env), 0);
        step();
        chk("mr_first_inc", int'(bus_a.env), 64);

        // Final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
